spi_cs_txn_ctrl: RTL

//  Transaction controller directly upstream of SPI_Master; feeds its byte TX port, collects RX bytes.

---
 rtl/spi_txn_pkg.sv | 19 +
 rtl/spi_txn_timer.sv | 39 +++
 rtl/spi_cs_txn_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_pkg.sv
// Shared types and helpers for the SPI chip-select transaction controller.
package spi_txn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CS_SETUP  = 3'd1,
        XFER      = 3'd2,
        WAIT_NEXT = 3'd3,
        CS_HOLD   = 3'd4,
        CS_GAP    = 3'd5
    } state_t;

    typedef logic [7:0] byte_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_txn_timer.sv
// Loadable down-counter shared by the CS setup, hold, gap and WAIT_NEXT timeout intervals.
// Loading N-1 on state entry makes o_Done rise after N full cycles in that state.
module spi_txn_timer #(
    parameter int TW = 4
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Load,
    input  logic [TW-1:0] i_Load_Val,
    output logic          o_Done
);

    logic [TW-1:0] cnt_d;
    logic [TW-1:0] cnt_q;

    // Next count: reload has priority, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Load) begin
            cnt_d = i_Load_Val;
        end else if (cnt_q != {TW{1'b0}}) begin
            cnt_d = cnt_q - TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Done = (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/spi_cs_txn_ctrl.sv
// Groups bytes for an upstream SPI master into chip-select windows with setup/hold/gap timing.
// Optional WAIT_NEXT idle abort is built when SPI_CS_TIMEOUT_EN is defined.
module spi_cs_txn_ctrl
    import spi_txn_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 1,
    parameter int TIMEOUT_CLKS     = 64,
    parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [7:0]    o_M_TX_Byte,
    output logic          o_M_TX_DV,
    input  logic          i_M_TX_Ready,
    input  logic          i_M_RX_DV,
    input  logic [7:0]    i_M_RX_Byte,
    output logic          o_SPI_CS_n,
    output logic          o_Timeout
);

    localparam int T_MAX = max_int(max_int(CS_SETUP_CLKS, CS_HOLD_CLKS),
                                   max_int(CS_INACTIVE_CLKS, TIMEOUT_CLKS));
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t        state_d, state_q;
    logic          cs_n_d, cs_n_q;
    logic          m_tx_dv_d, m_tx_dv_q;
    byte_t         m_tx_byte_d, m_tx_byte_q;
    logic          rx_dv_d, rx_dv_q;
    byte_t         rx_byte_d, rx_byte_q;
    logic [CW-1:0] rx_count_d, rx_count_q;
    logic [CW-1:0] remaining_d, remaining_q;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_done_s;
    logic          tx_ready_s;
    logic          tx_accept_s;
`ifdef SPI_CS_TIMEOUT_EN
    logic          timeout_d, timeout_q;
`endif

    spi_txn_timer #(
        .TW(TW)
    ) u_timer (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Load    (tmr_load_s),
        .i_Load_Val(tmr_val_s),
        .o_Done    (tmr_done_s)
    );

    // The pending master pulse blocks a second accept before the master drops its ready.
    assign tx_ready_s  = ((state_q == IDLE) || (state_q == WAIT_NEXT)) && i_M_TX_Ready && !m_tx_dv_q;
    assign tx_accept_s = tx_ready_s && i_TX_DV;

    // Next-state and output decode for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        m_tx_dv_d   = 1'b0;
        m_tx_byte_d = m_tx_byte_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_count_d  = rx_count_q;
        remaining_d = remaining_q;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {TW{1'b0}};
`ifdef SPI_CS_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (tx_accept_s && (i_TX_Count != {CW{1'b0}})) begin
                    if (i_TX_Count > CW'(MAX_BYTES_PER_CS)) begin
                        remaining_d = CW'(MAX_BYTES_PER_CS) - CW'(1);
                    end else begin
                        remaining_d = i_TX_Count - CW'(1);
                    end
                    m_tx_byte_d = i_TX_Byte;
                    rx_count_d  = {CW{1'b0}};
                    cs_n_d      = 1'b0;
                    state_d     = CS_SETUP;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TW'(CS_SETUP_CLKS - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            CS_SETUP: begin
                if (tmr_done_s && i_M_TX_Ready) begin
                    m_tx_dv_d = 1'b1;
                    state_d   = XFER;
                end else begin
                    state_d = CS_SETUP;
                end
            end
            XFER: begin
                if (i_M_RX_DV) begin
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_M_RX_Byte;
                    rx_count_d = rx_count_q + CW'(1);
                    tmr_load_s = 1'b1;
                    if (remaining_q == {CW{1'b0}}) begin
                        state_d   = CS_HOLD;
                        tmr_val_s = TW'(CS_HOLD_CLKS - 1);
                    end else begin
                        state_d   = WAIT_NEXT;
                        tmr_val_s = TW'(TIMEOUT_CLKS - 1);
                    end
                end else begin
                    state_d = XFER;
                end
            end
            WAIT_NEXT: begin
                if (tx_accept_s) begin
                    m_tx_byte_d = i_TX_Byte;
                    m_tx_dv_d   = 1'b1;
                    remaining_d = remaining_q - CW'(1);
                    state_d     = XFER;
                end
`ifdef SPI_CS_TIMEOUT_EN
                else if (tmr_done_s) begin
                    // Abandon the rest of the window but still honour the hold time.
                    timeout_d   = 1'b1;
                    remaining_d = {CW{1'b0}};
                    state_d     = CS_HOLD;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TW'(CS_HOLD_CLKS - 1);
                end
`endif
                else begin
                    state_d = WAIT_NEXT;
                end
            end
            CS_HOLD: begin
                if (tmr_done_s) begin
                    cs_n_d     = 1'b1;
                    state_d    = CS_GAP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TW'(CS_INACTIVE_CLKS - 1);
                end else begin
                    state_d = CS_HOLD;
                end
            end
            CS_GAP: begin
                if (tmr_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CS_GAP;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset raises CS_n without waiting for a clock.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            cs_n_q      <= 1'b1;
            m_tx_dv_q   <= 1'b0;
            m_tx_byte_q <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_count_q  <= {CW{1'b0}};
            remaining_q <= {CW{1'b0}};
`ifdef SPI_CS_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            m_tx_dv_q   <= m_tx_dv_d;
            m_tx_byte_q <= m_tx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
            remaining_q <= remaining_d;
`ifdef SPI_CS_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_TX_Ready  = tx_ready_s;
    assign o_RX_Count  = rx_count_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;
`ifdef SPI_CS_TIMEOUT_EN
    assign o_Timeout   = timeout_q;
`else
    assign o_Timeout   = 1'b0;
`endif

endmodule
